// File: rtl/dsconv_bn_if.sv
// Control bus between the depthwise-conv BN sequencer and its memories/datapath.
// The master side is the controller; the slave side is the start source and consumers.
interface dsconv_bn_if #(
  parameter int CH_W   = 5,
  parameter int ADDR_W = 11
);
  logic              start;
  logic              busy;
  logic              done;
  logic              param_rd_en;
  logic [CH_W-1:0]   param_addr;
  logic              param_load;
  logic              pix_rd_en;
  logic [ADDR_W-1:0] pix_rd_addr;
  logic              bn_start;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;

  modport master (
    input  start,
    output busy, done, param_rd_en, param_addr, param_load,
           pix_rd_en, pix_rd_addr, bn_start, out_wr_en, out_wr_addr
  );

  modport slave (
    output start,
    input  busy, done, param_rd_en, param_addr, param_load,
           pix_rd_en, pix_rd_addr, bn_start, out_wr_en, out_wr_addr
  );
endinterface

// File: rtl/dsconv_bn_controller.sv
// Sequences per-channel p/q loads and pixel streaming through the BN datapath,
// writing each result two cycles after its read address.
module dsconv_bn_controller #(
  parameter int CH_NUM  = 32,
  parameter int PIX_NUM = 64,
  parameter int CH_W    = 5,
  parameter int ADDR_W  = 11
) (
  input  logic        clk,
  input  logic        rst,
  dsconv_bn_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD_PARAM, WAIT_PARAM, RUN, DRAIN, DONE
  } state_e;

  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CH_NUM - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_NUM - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drain_q, drain_d;
  logic              bn_q, wr_q;
  logic [ADDR_W-1:0] addr_d1_q, addr_d2_q;
  logic              pix_rd_en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      pix_q     <= '0;
      addr_q    <= '0;
      drain_q   <= 1'b0;
      bn_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_d1_q <= '0;
      addr_d2_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      pix_q     <= pix_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      bn_q      <= pix_rd_en;
      wr_q      <= bn_q;
      addr_d1_q <= addr_q;
      addr_d2_q <= addr_d1_q;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:       if (bus.start) state_d = LOAD_PARAM;
      LOAD_PARAM: state_d = WAIT_PARAM;
      WAIT_PARAM: state_d = RUN;
      RUN: begin
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (ch_q == CH_LAST) begin
            // Hold the final address so the flat counter never wraps.
            state_d = DRAIN;
            drain_d = 1'b0;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = LOAD_PARAM;
          end
        end else begin
          pix_d  = pix_q + ADDR_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        ch_d    = '0;
        pix_d   = '0;
        addr_d  = '0;
        drain_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_rd_en       = (state_q == RUN);
    bus.busy        = (state_q != IDLE);
    bus.done        = (state_q == DONE);
    bus.param_rd_en = (state_q == LOAD_PARAM);
    bus.param_load  = (state_q == WAIT_PARAM);
    bus.param_addr  = ch_q;
    bus.pix_rd_en   = pix_rd_en;
    bus.pix_rd_addr = addr_q;
    bus.bn_start    = bn_q;
    bus.out_wr_en   = wr_q;
    bus.out_wr_addr = addr_d2_q;
  end

endmodule
